// File: rtl/fft128_sequencer.sv
// Address/control sequencer for a 128-point radix-2 DIT FFT on one shared butterfly and one RAM.
// Optional macro FFT_STAGE_SCALE_EN: assert BfShift on every butterfly issue (1/2 per stage).
module fft128_sequencer #(
  parameter int unsigned BF_LAT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PushIn,
  input  logic       FirstData,
  output logic       WrEn,
  output logic [6:0] WrAddr,
  output logic       BfRdEn,
  output logic [6:0] BfRdA,
  output logic [6:0] BfRdB,
  output logic [5:0] TwIdx,
  output logic       BfShift,
  output logic       BfWrEn,
  output logic [6:0] BfWrA,
  output logic [6:0] BfWrB,
  output logic [2:0] Stage,
  output logic       RdEn,
  output logic [6:0] RdAddr,
  output logic       PushOut,
  output logic       FrameDone,
  output logic       Overrun
);

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned TW_W      = 6;
  localparam int unsigned STEP_W    = 7;
  localparam int unsigned STEP_LAST = 63 + BF_LAT;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   cnt, cntNext;
  logic [2:0]          stageCnt, stageCntNext;
  logic [STEP_W-1:0]   stepCnt, stepCntNext;

  logic              wrEnN, bfRdEnN, bfShiftN, rdEnN, overrunN;
  logic [ADDR_W-1:0] wrAddrN, bfRdAN, bfRdBN, rdAddrN;
  logic [TW_W-1:0]   twIdxN;
  logic [2:0]        stageN;

  logic [ADDR_W-1:0] mask, bfA, bfB;
  logic [TW_W-1:0]   bfPos, bfTw;

  logic              wbEn [BF_LAT];
  logic [ADDR_W-1:0] wbA  [BF_LAT];
  logic [ADDR_W-1:0] wbB  [BF_LAT];

  function automatic logic [ADDR_W-1:0] bitrev7(input logic [ADDR_W-1:0] x);
    logic [ADDR_W-1:0] r;
    for (int unsigned i = 0; i < ADDR_W; i++) r[i] = x[ADDR_W-1-i];
    return r;
  endfunction

  // Butterfly operands: insert a zero at bit 'stage' of the butterfly index.
  always_comb begin
    mask  = ADDR_W'((ADDR_W'(1) << stageCnt) - ADDR_W'(1));
    bfA   = ((ADDR_W'(stepCnt[5:0]) & ~mask) << 1) | (ADDR_W'(stepCnt[5:0]) & mask);
    bfB   = bfA | (ADDR_W'(1) << stageCnt);
    bfPos = stepCnt[5:0] & mask[TW_W-1:0];
    bfTw  = bfPos << (3'd6 - stageCnt);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      stageCnt <= '0;
      stepCnt  <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      stageCnt <= stageCntNext;
      stepCnt  <= stepCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    stageCntNext = stageCnt;
    stepCntNext  = stepCnt;
    wrEnN        = 1'b0;
    wrAddrN      = '0;
    bfRdEnN      = 1'b0;
    bfRdAN       = '0;
    bfRdBN       = '0;
    twIdxN       = '0;
    stageN       = Stage;
    rdEnN        = 1'b0;
    rdAddrN      = '0;
    overrunN     = Overrun;
    unique case (state)
      IDLE: begin
        if (PushIn && FirstData) begin
          wrEnN     = 1'b1;
          cntNext   = ADDR_W'(1);
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (PushIn) begin
          wrEnN = 1'b1;
          if (FirstData) begin
            cntNext = ADDR_W'(1);
          end else begin
            wrAddrN = bitrev7(cnt);
            if (cnt == ADDR_W'(127)) begin
              stateNext    = COMPUTE;
              cntNext      = '0;
              stageCntNext = '0;
              stepCntNext  = '0;
            end else begin
              cntNext = cnt + ADDR_W'(1);
            end
          end
        end
      end
      COMPUTE: begin
        if (stepCnt < STEP_W'(64)) begin
          bfRdEnN = 1'b1;
          bfRdAN  = bfA;
          bfRdBN  = bfB;
          twIdxN  = bfTw;
          stageN  = stageCnt;
        end
        // Steps 64..STEP_LAST are the drain gap that keeps the next stage off in-flight results.
        if (stepCnt == STEP_W'(STEP_LAST)) begin
          stepCntNext = '0;
          if (stageCnt == 3'd6) stateNext = UNLOAD;
          else stageCntNext = stageCnt + 3'd1;
        end else begin
          stepCntNext = stepCnt + STEP_W'(1);
        end
        if (PushIn) overrunN = 1'b1;
      end
      UNLOAD: begin
        rdEnN   = 1'b1;
        rdAddrN = cnt;
        if (cnt == ADDR_W'(127)) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + ADDR_W'(1);
        end
        if (PushIn) overrunN = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef FFT_STAGE_SCALE_EN
  assign bfShiftN = bfRdEnN;
`else
  assign bfShiftN = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      BfRdEn    <= 1'b0;
      BfRdA     <= '0;
      BfRdB     <= '0;
      TwIdx     <= '0;
      BfShift   <= 1'b0;
      Stage     <= '0;
      RdEn      <= 1'b0;
      RdAddr    <= '0;
      PushOut   <= 1'b0;
      FrameDone <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      WrEn      <= wrEnN;
      WrAddr    <= wrAddrN;
      BfRdEn    <= bfRdEnN;
      BfRdA     <= bfRdAN;
      BfRdB     <= bfRdBN;
      TwIdx     <= twIdxN;
      BfShift   <= bfShiftN;
      Stage     <= stageN;
      RdEn      <= rdEnN;
      RdAddr    <= rdAddrN;
      PushOut   <= RdEn;
      FrameDone <= RdEn && (RdAddr == ADDR_W'(127));
      Overrun   <= overrunN;
    end
  end

  // Write-back delay line mirroring the butterfly pipeline.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        wbEn[i] <= 1'b0;
        wbA[i]  <= '0;
        wbB[i]  <= '0;
      end
    end else begin
      wbEn[0] <= BfRdEn;
      wbA[0]  <= BfRdA;
      wbB[0]  <= BfRdB;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        wbEn[i] <= wbEn[i-1];
        wbA[i]  <= wbA[i-1];
        wbB[i]  <= wbB[i-1];
      end
    end
  end

  assign BfWrEn = wbEn[BF_LAT-1];
  assign BfWrA  = wbA[BF_LAT-1];
  assign BfWrB  = wbB[BF_LAT-1];

endmodule

// File: tb/tb_fft128_sequencer.sv
// Scoreboard bench for fft128_sequencer: a frame-level model predicts time-stamped output events.
module tb_fft128_sequencer;

  localparam int L = 4;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       PushIn = 1'b0;
  logic       FirstData = 1'b0;
  logic       WrEn, BfRdEn, BfShift, BfWrEn, RdEn, PushOut, FrameDone, Overrun;
  logic [6:0] WrAddr, BfRdA, BfRdB, BfWrA, BfWrB, RdAddr;
  logic [5:0] TwIdx;
  logic [2:0] Stage;

  fft128_sequencer #(.BF_LAT(L)) dut (
    .Clk(Clk), .Reset(Reset), .PushIn(PushIn), .FirstData(FirstData),
    .WrEn(WrEn), .WrAddr(WrAddr), .BfRdEn(BfRdEn), .BfRdA(BfRdA), .BfRdB(BfRdB),
    .TwIdx(TwIdx), .BfShift(BfShift), .BfWrEn(BfWrEn), .BfWrA(BfWrA), .BfWrB(BfWrB),
    .Stage(Stage), .RdEn(RdEn), .RdAddr(RdAddr), .PushOut(PushOut),
    .FrameDone(FrameDone), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int b; int t; int s; } ev_t;
  ev_t q[6][$];

  int total = 0;
  int bad = 0;
  bit started = 0;
  int zeroChk = -1;
  int ovCycle = -1;

  // Frame-level model state
  bit mBusy = 0;
  bit mLoad = 0;
  int mCnt = 0;
  int mBusyHi = 0;
  int mC0 = 0;

  function automatic int bitrev(input int x);
    int r = 0;
    for (int i = 0; i < 7; i++) if (x[i]) r |= (1 << (6 - i));
    return r;
  endfunction

  task automatic push(input int id, input int c, input int a, input int b, input int t, input int s);
    ev_t ev;
    ev = '{c, a, b, t, s};
    q[id].push_back(ev);
  endtask

  // Predict every event of one FFT run whose first butterfly issue is visible at cycle c0.
  task automatic planFrame(input int c0);
    int half, pos, grp, a, c, r0;
    mBusy = 1;
    mC0 = c0;
    for (int s = 0; s < 7; s++) begin
      half = 1 << s;
      for (int b = 0; b < 64; b++) begin
        pos = b % half;
        grp = b / half;
        a = grp * 2 * half + pos;
        c = c0 + s * (64 + L) + b;
        push(1, c, a, a + half, pos * (64 / half), s);
        push(2, c + L, a, a + half, 0, 0);
      end
    end
    r0 = c0 + 7 * (64 + L);
    for (int i = 0; i < 128; i++) begin
      push(3, r0 + i, i, 0, 0, 0);
      push(4, r0 + i + 1, 0, 0, 0, 0);
    end
    push(5, r0 + 128, 0, 0, 0, 0);
    mBusyHi = r0 + 127;
  endtask

  // Drive one cycle of inputs; they are sampled at edge cyc+1 and show up in outputs of that cycle.
  task automatic step(input bit p, input bit f);
    int e;
    e = cyc + 1;
    PushIn = p;
    FirstData = f;
    if (mBusy && e > mBusyHi) mBusy = 0;
    if (mBusy) begin
      if (p && ovCycle < 0) ovCycle = e;
    end else if (mLoad) begin
      if (p) begin
        if (f) mCnt = 0;
        push(0, e, bitrev(mCnt), 0, 0, 0);
        mCnt++;
        if (mCnt == 128) begin
          mLoad = 0;
          planFrame(e + 1);
        end
      end
    end else if (p && f) begin
      push(0, e, 0, 0, 0, 0);
      mCnt = 1;
      mLoad = 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    PushIn = 1'b0;
    FirstData = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int id = 0; id < 6; id++) q[id].delete();
    mBusy = 0;
    mLoad = 0;
    ovCycle = -1;
    zeroChk = cyc;
    started = 1;
  endtask

  task automatic loadFrame(input bit gaps, input bit restart);
    bit p, f, rs;
    int guard;
    rs = 0;
    guard = 0;
    step(1'b1, 1'b1);
    while (mLoad && guard < 3000) begin
      p = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      f = p ? 1'b0 : 1'($urandom_range(0, 1));
      if (restart && !rs && p && mCnt == 50) begin
        f = 1'b1;
        rs = 1;
      end
      step(p, f);
      guard++;
    end
  endtask

  task automatic runUntil(input bit inject, input int untilCycle);
    bit p;
    while (cyc < untilCycle) begin
      p = inject && ($urandom_range(0, 19) == 0);
      step(p, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic obs(input int id, input string nm, input int a, input int b, input int t, input int s);
    ev_t e;
    total++;
    if (q[id].size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event at cycle %0d a=%0d b=%0d t=%0d s=%0d", nm, cyc, a, b, t, s);
    end else begin
      e = q[id].pop_front();
      if (e.c != cyc || e.a != a || e.b != b || e.t != t || e.s != s) begin
        bad++;
        $display("FAIL %s: got cyc=%0d a=%0d b=%0d t=%0d s=%0d, want cyc=%0d a=%0d b=%0d t=%0d s=%0d",
                 nm, cyc, a, b, t, s, e.c, e.a, e.b, e.t, e.s);
      end
    end
  endtask

  // Monitor: sample outputs mid-cycle and score every event.
  always @(negedge Clk) begin
    if (started) begin
      if (cyc == zeroChk) begin
        total++;
        if ({WrEn, WrAddr, BfRdEn, BfRdA, BfRdB, TwIdx, BfShift, BfWrEn, BfWrA, BfWrB,
             Stage, RdEn, RdAddr, PushOut, FrameDone, Overrun} != '0) begin
          bad++;
          $display("FAIL reset_zero: outputs not all zero at cycle %0d (WrEn=%0b BfRdEn=%0b BfWrEn=%0b RdEn=%0b Stage=%0d Overrun=%0b)",
                   cyc, WrEn, BfRdEn, BfWrEn, RdEn, Stage, Overrun);
        end
      end
      total++;
      if (Overrun !== (ovCycle >= 0 && cyc >= ovCycle)) begin
        bad++;
        $display("FAIL overrun: got %0b want %0b at cycle %0d", Overrun, (ovCycle >= 0 && cyc >= ovCycle), cyc);
      end
      total++;
      if (BfShift !== (BfRdEn & SCALE)) begin
        bad++;
        $display("FAIL bfshift: got %0b want %0b at cycle %0d", BfShift, BfRdEn & SCALE, cyc);
      end
      if (WrEn)      obs(0, "wraddr", int'(WrAddr), 0, 0, 0);
      if (BfRdEn)    obs(1, "issue", int'(BfRdA), int'(BfRdB), int'(TwIdx), int'(Stage));
      if (BfWrEn)    obs(2, "writeback", int'(BfWrA), int'(BfWrB), 0, 0);
      if (RdEn)      obs(3, "rdaddr", int'(RdAddr), 0, 0, 0);
      if (PushOut)   obs(4, "pushout", 0, 0, 0, 0);
      if (FrameDone) obs(5, "framedone", 0, 0, 0, 0);
    end
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    doReset();
    step(1'b0, 1'b0);

    // Frame A: stray push in IDLE is ignored, then a back-to-back load.
    step(1'b1, 1'b0);
    loadFrame(1'b0, 1'b0);
    runUntil(1'b0, mBusyHi);

    // Frame B starts in the first IDLE cycle; restart at sample 50; drops during compute.
    loadFrame(1'b1, 1'b1);
    runUntil(1'b1, mBusyHi - 1);
    step(1'b1, 1'b0);

    // Frame C: Overrun stays sticky; reset lands in stage 4.
    loadFrame(1'b1, 1'b0);
    runUntil(1'b1, mC0 + 4 * (64 + L) + 10);
    doReset();

    // Frame D: clean frame after the mid-compute reset.
    step(1'b1, 1'b0);
    loadFrame(1'b1, 1'b0);
    runUntil(1'b0, mBusyHi + 10);

    for (int id = 0; id < 6; id++) begin
      total++;
      if (q[id].size() != 0) begin
        bad++;
        $display("FAIL leftover: stream %0d has %0d missing events, next due cycle %0d", id, q[id].size(), q[id][0].c);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
